// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers a loaded program and issues it onto instruct (run or single-step).
// Optional feature macro SEQ_LOOP_EN: RUN wraps to word 0 after the last word instead of entering DONE.
module instr_sequencer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [19:0]       load_data,
    input  logic              clear,
    input  logic              start,
    input  logic              step,
    input  logic              halt,
    output logic [19:0]       instruct,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);
    localparam int unsigned IW = 20;
    localparam int unsigned CW = ADDR_W + 1;
    localparam logic [IW-1:0] NOP = '0;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] pc_q, pc_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [IW-1:0] mem_q [DEPTH];

    logic          load_fire;
    logic [CW-1:0] len_eff;
    logic [CW-1:0] pc_inc;
    logic [IW-1:0] cur_word;

    // pc carries one extra bit so a full buffer can report pc==len after the last word
    assign load_ready = (state_q == S_IDLE) && (len_q < CW'(DEPTH)) && (pc_q == '0);
    assign load_fire  = load_valid && load_ready;
    assign len_eff    = len_q + CW'(load_fire);
    assign pc_inc     = pc_q + CW'(1);
    assign cur_word   = mem_q[pc_q[ADDR_W-1:0]];

    // Next-state and next-output logic; priority halt > clear > start > step
    always_comb begin
        state_d = state_q;
        len_d   = len_eff;
        pc_d    = pc_q;
        instr_d = NOP;
        unique case (state_q)
            S_IDLE: begin
                if (!halt) begin
                    if (clear) begin
                        len_d = '0;
                        pc_d  = '0;
                    end else if (start && (len_eff > pc_q)) begin
                        state_d = S_RUN;
                    end else if (step && (len_eff > pc_q)) begin
                        state_d = S_STEP;
                    end
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_d = S_IDLE;
`ifdef SEQ_LOOP_EN
                end else begin
                    instr_d = cur_word;
                    pc_d    = (pc_inc >= len_q) ? '0 : pc_inc;
                end
`else
                end else if (pc_q >= len_q) begin
                    state_d = S_DONE;
                end else begin
                    instr_d = cur_word;
                    pc_d    = pc_inc;
                end
`endif
            end
            S_STEP: begin
                if (halt) begin
                    state_d = S_IDLE;
                end else begin
                    instr_d = cur_word;
                    pc_d    = pc_inc;
                    state_d = (pc_inc >= len_q) ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                if (!halt) begin
                    if (clear) begin
                        len_d   = '0;
                        pc_d    = '0;
                        state_d = S_IDLE;
                    end else if (start) begin
                        pc_d    = '0;
                        state_d = S_RUN;
                    end else if (step) begin
                        pc_d    = '0;
                        state_d = S_STEP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            pc_q    <= '0;
            instr_q <= NOP;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Program storage has no reset; contents are only meaningful below len
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem_q[len_q[ADDR_W-1:0]] <= load_data;
        end
    end

    assign instruct = instr_q;
    assign pc       = pc_q[ADDR_W-1:0];
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);

endmodule
